// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: reusable inter-stage pipeline register.
// Carries NUM_CH opaque channels of DATA_W bits behind a valid/ready handshake.
// A two-entry (main + skid) buffer keeps in_ready a pure register, so a
// downstream stall never reaches upstream combinationally. flush empties the
// stage and inserts a bubble. A saturating counter records output stall cycles.
module pipe_stage_buf #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     flush,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  localparam int unsigned W = NUM_CH * DATA_W;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           main_q, main_d;
  logic [W-1:0]           skid_q, skid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   accept_s;
  logic                   take_s;

  assign accept_s = in_valid & in_ready_q;
  assign take_s   = out_valid_q & out_ready;

  // Next-state and storage update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && take_s) begin
            main_d = in_data;
          end else if (accept_s) begin
            skid_d  = in_data;
            state_d = ST_SKID;
          end else if (take_s) begin
            // Zeroing main keeps out_data a NOP while the stage is empty.
            main_d  = '0;
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the older skid word can move up.
          if (take_s) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_FULL;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Handshake flags are decoded from the next state so they can be registered.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  // Saturating count of cycles where a valid word is held back by downstream.
  always_comb begin
    if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State, storage and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three parameterisations share one handshake
// stream and are compared every cycle against a queue-based reference model,
// with directed scenarios pinned by hand-computed literal values.
module tb_pipe_stage_buf;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic         flush;
  logic [191:0] in_w;

  // dut0: 32x4, 16-bit counter
  logic         in_ready0, out_valid0;
  logic [127:0] out_data0;
  logic [15:0]  stall0;
  // dut1: 8x1, 3-bit counter
  logic         in_ready1, out_valid1;
  logic [7:0]   out_data1;
  logic [2:0]   stall1;
  // dut2: 32x6, 16-bit counter
  logic         in_ready2, out_valid2;
  logic [191:0] out_data2;
  logic [15:0]  stall2;

  logic [127:0] in_data0;
  logic [7:0]   in_data1;
  assign in_data0 = in_w[127:0];
  assign in_data1 = in_w[7:0];

  pipe_stage_buf #(.DATA_W(32), .NUM_CH(4), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .flush(flush), .stall_cnt(stall0));

  pipe_stage_buf #(.DATA_W(8), .NUM_CH(1), .STALL_CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .flush(flush), .stall_cnt(stall1));

  pipe_stage_buf #(.DATA_W(32), .NUM_CH(6), .STALL_CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_w), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .flush(flush), .stall_cnt(stall2));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: words currently held by the stage, oldest first.
  logic [191:0] mq[$];
  int           m_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a stage holding at most two words in arrival order.
  always @(posedge clk or posedge reset) begin
    bit acc, tk;
    if (reset) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (mq.size() > 0 && !out_ready) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        acc = in_valid && (mq.size() < 2);
        tk  = (mq.size() > 0) && out_ready;
        if (tk) void'(mq.pop_front());
        if (acc) mq.push_back(in_w);
      end
    end
  end

  // Per-cycle comparison of every DUT against the model.
  always @(negedge clk) begin
    logic         ev, er;
    logic [191:0] ew;
    int           es16, es3;
    if (chk_en && !reset) begin
      ev   = (mq.size() > 0);
      er   = (mq.size() < 2);
      ew   = ev ? mq[0] : 192'd0;
      es16 = (m_stall > 65535) ? 65535 : m_stall;
      es3  = (m_stall > 7) ? 7 : m_stall;
      chk("d0_valid", {191'd0, out_valid0}, {191'd0, ev});
      chk("d0_ready", {191'd0, in_ready0},  {191'd0, er});
      chk("d0_data",  {64'd0, out_data0},   {64'd0, ew[127:0]});
      chk("d0_stall", {176'd0, stall0},     192'(es16));
      chk("d1_valid", {191'd0, out_valid1}, {191'd0, ev});
      chk("d1_ready", {191'd0, in_ready1},  {191'd0, er});
      chk("d1_data",  {184'd0, out_data1},  {184'd0, ew[7:0]});
      chk("d1_stall", {189'd0, stall1},     192'(es3));
      chk("d2_valid", {191'd0, out_valid2}, {191'd0, ev});
      chk("d2_ready", {191'd0, in_ready2},  {191'd0, er});
      chk("d2_data",  out_data2,            ew);
      chk("d2_stall", {176'd0, stall2},     192'(es16));
    end
  end

  task automatic step(input logic v, input logic [191:0] w, input logic r, input logic f);
    in_valid  = v;
    in_w      = w;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", {191'd0, out_valid0}, 192'd0);
    chk("rst_ready", {191'd0, in_ready0},  192'd1);
    chk("rst_stall", {176'd0, stall0},     192'd0);
    chk("rst_data",  {64'd0, out_data0},   192'd0);
    chk("rst_valid2", {191'd0, out_valid2}, 192'd0);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  logic [191:0] pt, wa, wb, wc, wd, rw;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_w = 192'd0;
    pt = {64'd0, 32'h12345678, 32'h00003008, 32'h00003004, 32'h8C010004};
    wa = {6{32'hAAAA0001}};
    wb = {6{32'hBBBB0002}};
    wc = {6{32'hCCCC0003}};
    wd = {6{32'hDDDD0004}};
    #12 reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", {191'd0, out_valid0}, 192'd0);
    chk("reset_ready", {191'd0, in_ready0},  192'd1);
    chk("reset_data",  {64'd0, out_data0},   192'd0);
    chk("reset_stall", {176'd0, stall0},     192'd0);
    chk_en = 1'b1;

    // Pass-through of one MIPS MEM/WB word.
    step(1'b1, pt, 1'b1, 1'b0);
    chk("pt_valid", {191'd0, out_valid0}, 192'd1);
    chk("pt_data",  {64'd0, out_data0}, {64'd0, 128'h12345678_00003008_00003004_8C010004});
    step(1'b0, 192'd0, 1'b1, 1'b0);
    chk("pt_bubble_valid", {191'd0, out_valid0}, 192'd0);
    chk("pt_bubble_data",  {64'd0, out_data0}, 192'd0);

    // Skid fill: A held, B in skid, C waits while in_ready is low.
    step(1'b1, wa, 1'b1, 1'b0);
    step(1'b1, wb, 1'b0, 1'b0);
    chk("skid_a_held", {64'd0, out_data0}, {64'd0, wa[127:0]});
    chk("skid_ready0", {191'd0, in_ready0}, 192'd0);
    step(1'b1, wc, 1'b0, 1'b0);
    step(1'b1, wc, 1'b0, 1'b0);
    chk("skid_stall3", {176'd0, stall0}, 192'd3);
    step(1'b1, wc, 1'b1, 1'b0);
    chk("skid_b_out", {64'd0, out_data0}, {64'd0, wb[127:0]});
    step(1'b1, wc, 1'b1, 1'b0);
    chk("skid_c_out", {64'd0, out_data0}, {64'd0, wc[127:0]});
    step(1'b0, 192'd0, 1'b1, 1'b0);
    chk("skid_drained", {191'd0, out_valid0}, 192'd0);

    // Flush while in SKID with D offered: bubble, D dropped.
    step(1'b1, wa, 1'b1, 1'b0);
    step(1'b1, wb, 1'b0, 1'b0);
    step(1'b1, wd, 1'b1, 1'b1);
    chk("flush_valid", {191'd0, out_valid0}, 192'd0);
    chk("flush_data",  {64'd0, out_data0},   192'd0);
    chk("flush_ready", {191'd0, in_ready0},  192'd1);
    chk("flush_keep_stall", {176'd0, stall0}, 192'd4);
    step(1'b0, 192'd0, 1'b1, 1'b0);
    chk("flush_no_d", {191'd0, out_valid0}, 192'd0);

    // Asynchronous reset while in SKID with stall_cnt=5.
    step(1'b1, wa, 1'b1, 1'b0);
    step(1'b1, wb, 1'b0, 1'b0);
    chk("pre_rst_stall", {176'd0, stall0}, 192'd5);
    chk("pre_rst_ready", {191'd0, in_ready0}, 192'd0);
    pulse_reset();
    step(1'b0, 192'd0, 1'b1, 1'b0);
    chk("post_rst_empty", {191'd0, out_valid0}, 192'd0);

    // Saturation of the 3-bit counter over 10 stall cycles.
    step(1'b1, wa, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 192'd0, 1'b0, 1'b0);
    chk("sat_d1_7",  {189'd0, stall1}, 192'd7);
    chk("sat_d0_10", {176'd0, stall0}, 192'd10);
    for (int i = 0; i < 5; i++) step(1'b0, 192'd0, 1'b0, 1'b0);
    chk("sat_d1_hold", {189'd0, stall1}, 192'd7);

    // Random traffic: mostly-ready, then heavy backpressure.
    pulse_reset();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        rw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        step(1'($urandom_range(0, 3) != 0), rw,
             (ph == 0) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 40) == 0));
      end
    end
    // Drain remaining words through the model check.
    for (int i = 0; i < 4; i++) step(1'b0, 192'd0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register that replaces the fixed-field inter-stage latches of the five-stage MIPS core with one reusable block. It carries NUM_CH channels of DATA_W bits each, for example IR, PC4, PC8 and DM between MEM and WB. It has a valid/ready handshake with a two-entry skid buffer, so a downstream stall never combinationally reaches upstream. It also supports synchronous flush with bubble insertion, and a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- DATA_W, 32, width of one channel
- NUM_CH, 4, number of channels; channel k occupies bits [k*DATA_W +: DATA_W]
- STALL_CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  upstream presents a word
- in_ready  out  1  block can accept; driven only by a register
- in_data  in  NUM_CH*DATA_W  packed channel data
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream takes the word this cycle
- out_data  out  NUM_CH*DATA_W  packed channel data; all zeros (NOP) when out_valid=0
- flush  in  1  synchronous kill of all held contents
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- accept = in_valid & in_ready; take = out_valid & out_ready.
- Storage consists of a main register (drives out_data) and a skid register.
- State is EMPTY, FULL or SKID. out_valid = (state != EMPTY). in_ready = (state != SKID), held as a flop.
- EMPTY: on accept, main <= in_data and go to FULL.
- FULL:
  - accept & take: main <= in_data, stay in FULL.
  - accept & !take: skid <= in_data, go to SKID.
  - !accept & take: main <= 0, go to EMPTY.
  - Otherwise hold.
- SKID: accept is impossible because in_ready=0. On take, main <= skid, skid <= 0, go to FULL. Otherwise hold.
- Zeroing main on entry to EMPTY keeps out_data at 0 whenever out_valid=0. WB therefore sees IR=0, a NOP.
- flush has priority over every handshake. On the next edge, state becomes EMPTY, main and skid are cleared, and in_ready becomes 1. A word offered in the flush cycle is dropped even if in_ready=1. A take in the flush cycle still completes downstream, because downstream samples before the edge.
- stall_cnt increments on each edge where out_valid & !out_ready. It saturates at 2^STALL_CNT_W-1. flush does not clear it; only reset does.
- Channels are opaque and carry no per-channel logic. Widths are exact, with no truncation or extension.

## Timing
- Reset values:
  - state = EMPTY.
  - out_valid = 0, out_data = 0, stall_cnt = 0.
  - in_ready = 1 (the flop resets to 1).
  - skid = 0.
- Reset asserted mid-transfer discards all held words asynchronously. Outputs take their reset values without waiting for a clock edge.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one word per cycle while out_ready=1.
- Backpressure: out_ready drops at cycle N while FULL and a word is accepted. in_ready then falls after edge N. At most one extra word is absorbed, into skid.
- Ordering is strict FIFO: skid is always older than the next incoming word, and main is always older than skid.
- Simultaneous reset and flush: reset wins.
- Simultaneous flush with accept or take: flush wins for internal state.

## Test plan
- Pass-through: out_ready=1, feed IR=0x8C010004, PC4=0x3004, PC8=0x3008, DM=0x12345678, each for one cycle. The word appears one cycle later with out_valid=1. Next cycle out_valid=0 and out_data=0.
- Skid fill: stream words A, B, C with out_ready=0 from the cycle after A is accepted. A is held on out_data, B goes into skid, and in_ready=0 while C waits. Release out_ready. The outputs are A, B, C in order with no loss or duplicate. stall_cnt equals the number of stalled cycles.
- Flush in SKID: with A in main and B in skid, assert flush for one cycle while in_valid=1 with D. Next cycle out_valid=0, out_data=0 and in_ready=1. D is never output.
- Async reset mid-stall: in state SKID, with stall_cnt=5, pulse reset between clock edges. Outputs clear immediately: out_valid=0, stall_cnt=0, in_ready=1. No earlier word is output afterwards.
- Counter saturation: set STALL_CNT_W=3 and hold out_valid=1, out_ready=0 for 10 cycles. stall_cnt reaches 7 and stays at 7.
- Parameter sweep: DATA_W=8, NUM_CH=1, and DATA_W=32, NUM_CH=6, each with random valid/ready. Output equals the input sequence exactly, and out_data=0 whenever out_valid=0.
